// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Program counter and fetch controller placed directly upstream of the
// instruction memory. It drives the memory address and program selection,
// latches the returned instruction into an instruction register, hands that
// register to the execute stage through a valid/done handshake, applies
// relative jumps resolved by the execute stage, stops on HALT (opcode 4'b1110)
// or on an out-of-range PC, and counts retired instructions (saturating).
//
// Optional feature (compile-time macro):
//   FETCH_PROG_RESTART_EN - when defined, a change of programSelectIn while in
//                           FETCH, ISSUE or HALT restarts the sequencer through
//                           IDLE. When undefined, programSelectIn is sampled
//                           only in IDLE.
//
// Parameters:
//   PROG_DEPTH  number of valid instruction slots; PC >= PROG_DEPTH is a fault
//   COUNT_W     width of the retired-instruction counter
//
// Ports:
//   clk              in   system clock, rising edge
//   rstN             in   synchronous active-low reset
//   programSelectIn  in   [7:0]  program selection switches
//   programSelect    out  [7:0]  latched selection to the instruction memory
//   address          out  [7:0]  current PC (direct copy of the PC register)
//   instruction      in   [15:0] combinational memory read data for address
//   instrReg         out  [15:0] latched instruction for the execute stage
//   instrValid       out         instrReg awaits execution
//   execDone         in          execute stage finished with instrReg
//   jumpTaken        in          qualifies execDone: apply jumpOffset
//   jumpOffset       in   [7:0]  two's-complement offset relative to PC+1
//   halted           out         sequencer stopped (HALT or fault)
//   fault            out         PC target reached >= PROG_DEPTH
//   instrCount       out  [COUNT_W-1:0] retired instructions, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned PROG_DEPTH = 128,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [7:0]         programSelectIn,
    output logic [7:0]         programSelect,
    output logic [7:0]         address,
    input  logic [15:0]        instruction,
    output logic [15:0]        instrReg,
    output logic               instrValid,
    input  logic               execDone,
    input  logic               jumpTaken,
    input  logic [7:0]         jumpOffset,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instrCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [3:0] OPC_HALT = 4'b1110;

    state_e               state_q;
    logic [7:0]           pc_q;
    logic [7:0]           sel_q;
    logic [15:0]          ir_q;
    logic                 valid_q;
    logic                 halted_q;
    logic                 fault_q;
    logic [COUNT_W-1:0]   cnt_q;

    logic [7:0]           next_pc_d;
    logic [COUNT_W-1:0]   cnt_d;
    logic                 in_range;
    logic                 is_halt;
    logic                 restart_req;

    // ------------------------------------------------------------------
    // Next-PC and counter arithmetic.
    // Adding the raw offset bits in 8 bits is the same as adding the
    // sign-extended offset modulo 256, so no explicit extension is needed.
    // ------------------------------------------------------------------
    always_comb begin
        next_pc_d = pc_q + 8'd1 + (jumpTaken ? jumpOffset : 8'd0);
        in_range  = ({24'd0, next_pc_d} < PROG_DEPTH);
        is_halt   = (instruction[15:12] == OPC_HALT);
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);
    end

`ifdef FETCH_PROG_RESTART_EN
    // Compare against the latched selection; IDLE never requests a restart
    // because it re-latches the switches itself.
    assign restart_req = (programSelectIn != sel_q);
`else
    assign restart_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            sel_q    <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sel_q   <= programSelectIn;
                    pc_q    <= '0;
                    state_q <= S_FETCH;
                end

                S_FETCH: begin
                    if (restart_req) begin
                        state_q  <= S_IDLE;
                        pc_q     <= '0;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                        cnt_q    <= '0;
                    end else if (is_halt) begin
                        // HALT opcode is not loaded into the IR.
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        ir_q    <= instruction;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (restart_req) begin
                        // Restart wins over a same-cycle execDone.
                        state_q  <= S_IDLE;
                        pc_q     <= '0;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                        cnt_q    <= '0;
                    end else if (execDone) begin
                        // The instruction retires even when its successor
                        // PC is out of range.
                        cnt_q   <= cnt_d;
                        valid_q <= 1'b0;
                        if (in_range) begin
                            pc_q    <= next_pc_d;
                            state_q <= S_FETCH;
                        end else begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    end
                end

                S_HALT: begin
                    if (restart_req) begin
                        state_q  <= S_IDLE;
                        pc_q     <= '0;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                        cnt_q    <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign programSelect = sel_q;
    assign address       = pc_q;
    assign instrReg      = ir_q;
    assign instrValid    = valid_q;
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign instrCount    = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed scenarios plus randomized program walks for fetch_sequencer.
// Expected values come from a transaction-level model: PC targets are computed
// with integer arithmetic modulo 256, instructions from a memory array.
// Optional feature macro honoured: FETCH_PROG_RESTART_EN.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  programSelectIn;
    logic [7:0]  programSelect;
    logic [7:0]  address;
    logic [15:0] instruction;
    logic [15:0] instrReg;
    logic        instrValid;
    logic        execDone;
    logic        jumpTaken;
    logic [7:0]  jumpOffset;
    logic        halted;
    logic        fault;
    logic [15:0] instrCount;

    logic [15:0] mem [256];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PROG_DEPTH(DEPTH),
        .COUNT_W   (16)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .programSelectIn(programSelectIn),
        .programSelect  (programSelect),
        .address        (address),
        .instruction    (instruction),
        .instrReg       (instrReg),
        .instrValid     (instrValid),
        .execDone       (execDone),
        .jumpTaken      (jumpTaken),
        .jumpOffset     (jumpOffset),
        .halted         (halted),
        .fault          (fault),
        .instrCount     (instrCount)
    );

    assign instruction = mem[address];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running required finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"},   32'(address),       32'h0);
        chk({tag, "_sel"},    32'(programSelect), 32'h0);
        chk({tag, "_ir"},     32'(instrReg),      32'h0);
        chk({tag, "_valid"},  32'(instrValid),    32'h0);
        chk({tag, "_halted"}, 32'(halted),        32'h0);
        chk({tag, "_fault"},  32'(fault),         32'h0);
        chk({tag, "_count"},  32'(instrCount),    32'h0);
    endtask

    // Reset, release, and advance through the IDLE cycle; returns in FETCH.
    task automatic start(input logic [7:0] sel);
        programSelectIn = sel;
        execDone        = 1'b0;
        jumpTaken       = 1'b0;
        jumpOffset      = 8'h00;
        rstN            = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // Complete the instruction in ISSUE; returns in the following cycle.
    task automatic issue(input logic jt, input logic [7:0] off);
        execDone   = 1'b1;
        jumpTaken  = jt;
        jumpOffset = off;
        tick();
        execDone   = 1'b0;
        jumpTaken  = 1'b0;
    endtask

    task automatic fill_mem(input int halt_pct);
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hE) w[15:12] = 4'h0;
            if (int'($urandom_range(0, 99)) < halt_pct) w[15:12] = 4'hE;
            mem[i] = w;
        end
    endtask

    // Random program walk checked against the transaction-level model.
    task automatic walk(input logic [7:0] sel);
        int   exp_pc;
        int   exp_cnt;
        int   tgt;
        int   o;
        int   stall;
        bit   done;
        logic jt;
        logic [7:0] off;
        logic [15:0] word;

        start(sel);
        exp_pc  = 0;
        exp_cnt = 0;
        done    = 0;
        chk("walk_sel", 32'(programSelect), 32'(sel));
        chk("walk_first_addr", 32'(address), 32'h0);
        for (int step = 0; step < 40 && !done; step++) begin
            word = mem[exp_pc];
            tick();
            if (word[15:12] == 4'hE) begin
                chk("walk_halt_flag",  32'(halted),     32'h1);
                chk("walk_halt_addr",  32'(address),    32'(exp_pc));
                chk("walk_halt_valid", 32'(instrValid), 32'h0);
                chk("walk_halt_count", 32'(instrCount), 32'(exp_cnt));
                chk("walk_halt_fault", 32'(fault),      32'h0);
                done = 1;
            end else begin
                chk("walk_valid", 32'(instrValid), 32'h1);
                chk("walk_ir",    32'(instrReg),   32'(word));
                chk("walk_addr",  32'(address),    32'(exp_pc));
                stall = int'($urandom_range(0, 3));
                for (int s = 0; s < stall; s++) begin
                    jumpTaken = 1'($urandom);
                    tick();
                    chk("walk_stall_valid", 32'(instrValid), 32'h1);
                    chk("walk_stall_ir",    32'(instrReg),   32'(word));
                    chk("walk_stall_count", 32'(instrCount), 32'(exp_cnt));
                end
                jt = 1'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    off = 8'($urandom_range(0, 255));
                end else begin
                    o   = int'($urandom_range(0, 15)) - 8;
                    off = 8'(o);
                end
                issue(jt, off);
                jumpTaken = 1'($urandom);
                exp_cnt++;
                tgt = (exp_pc + 1 + (jt ? int'($signed(off)) : 0)) & 255;
                if (tgt < DEPTH) begin
                    exp_pc = tgt;
                    chk("walk_next_addr",  32'(address),    32'(exp_pc));
                    chk("walk_next_valid", 32'(instrValid), 32'h0);
                    chk("walk_next_count", 32'(instrCount), 32'(exp_cnt));
                    chk("walk_next_fault", 32'(fault),      32'h0);
                end else begin
                    chk("walk_fault_flag",  32'(fault),      32'h1);
                    chk("walk_fault_halt",  32'(halted),     32'h1);
                    chk("walk_fault_addr",  32'(address),    32'(exp_pc));
                    chk("walk_fault_valid", 32'(instrValid), 32'h0);
                    chk("walk_fault_count", 32'(instrCount), 32'(exp_cnt));
                    done = 1;
                end
            end
        end
        jumpTaken = 1'b0;
        if (done) begin
            execDone = 1'b1;
            tick();
            tick();
            execDone = 1'b0;
            chk("walk_post_halt",  32'(halted),     32'h1);
            chk("walk_post_count", 32'(instrCount), 32'(exp_cnt));
            chk("walk_post_addr",  32'(address),    32'(exp_pc));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        programSelectIn = 8'h00;
        execDone        = 1'b0;
        jumpTaken       = 1'b0;
        jumpOffset      = 8'h00;
        rstN            = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_state("reset");

        // Straight-line program with execDone held high
        mem[0] = 16'h0102;
        mem[1] = 16'h2F10;
        mem[2] = 16'hE000;
        programSelectIn = 8'h01;
        execDone = 1'b1;
        rstN     = 1'b1;
        tick();                                         // cycle 1: FETCH
        chk("sl_c1_addr",  32'(address),       32'h0);
        chk("sl_c1_valid", 32'(instrValid),    32'h0);
        chk("sl_c1_sel",   32'(programSelect), 32'h01);
        tick();                                         // cycle 2
        chk("sl_c2_valid", 32'(instrValid), 32'h1);
        chk("sl_c2_ir",    32'(instrReg),   32'h0102);
        tick();                                         // cycle 3
        chk("sl_c3_valid", 32'(instrValid), 32'h0);
        chk("sl_c3_addr",  32'(address),    32'h1);
        chk("sl_c3_count", 32'(instrCount), 32'h1);
        tick();                                         // cycle 4
        chk("sl_c4_ir",    32'(instrReg),   32'h2F10);
        chk("sl_c4_valid", 32'(instrValid), 32'h1);
        tick();                                         // cycle 5
        chk("sl_c5_addr",  32'(address),    32'h2);
        tick();                                         // cycle 6: halted
        chk("sl_halted",   32'(halted),     32'h1);
        chk("sl_addr",     32'(address),    32'h2);
        chk("sl_count",    32'(instrCount), 32'h2);
        chk("sl_valid",    32'(instrValid), 32'h0);
        chk("sl_ir_kept",  32'(instrReg),   32'h2F10);
        chk("sl_fault",    32'(fault),      32'h0);
        execDone = 1'b0;

        // Backward jump, self re-execution, stall, reset mid-ISSUE
        for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
        start(8'h01);
        tick();
        issue(1'b1, 8'd11);
        chk("bj_to12", 32'(address), 32'd12);
        tick();
        issue(1'b1, 8'hF6);
        chk("bj_addr",  32'(address),    32'd3);
        chk("bj_count", 32'(instrCount), 32'd2);
        tick();
        issue(1'b1, 8'hFF);
        chk("self_addr",  32'(address),    32'd3);
        chk("self_count", 32'(instrCount), 32'd3);
        tick();
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_valid", 32'(instrValid), 32'h1);
            chk("stall_ir",    32'(instrReg),   32'h1234);
            chk("stall_addr",  32'(address),    32'd3);
            chk("stall_count", 32'(instrCount), 32'd3);
        end
        execDone  = 1'b1;
        jumpTaken = 1'b1;
        rstN      = 1'b0;
        tick();
        execDone  = 1'b0;
        jumpTaken = 1'b0;
        chk_reset_state("rst_issue");
        rstN = 1'b1;

        // Fault from a jump at PC 120
        start(8'h01);
        tick();
        issue(1'b1, 8'h77);
        chk("flt_to120", 32'(address), 32'd120);
        tick();
        issue(1'b1, 8'h10);
        chk("flt_fault", 32'(fault),      32'h1);
        chk("flt_halt",  32'(halted),     32'h1);
        chk("flt_addr",  32'(address),    32'd120);
        chk("flt_valid", 32'(instrValid), 32'h0);
        chk("flt_count", 32'(instrCount), 32'd2);
        execDone = 1'b1;
        tick();
        tick();
        tick();
        execDone = 1'b0;
        chk("flt_ignore_count", 32'(instrCount), 32'd2);
        chk("flt_ignore_addr",  32'(address),    32'd120);

        // Boundary: jump to last slot is legal, sequential step past it faults
        start(8'h01);
        tick();
        issue(1'b1, 8'h7E);
        chk("bnd_addr127",  32'(address), 32'd127);
        chk("bnd_nofault",  32'(fault),   32'h0);
        tick();
        issue(1'b0, 8'h00);
        chk("bnd_fault",    32'(fault),      32'h1);
        chk("bnd_addr",     32'(address),    32'd127);
        chk("bnd_count",    32'(instrCount), 32'd2);

        // Wrap: PC 5 + 1 + (-16) = 246 -> fault
        start(8'h01);
        tick();
        issue(1'b1, 8'h04);
        chk("wrap_to5", 32'(address), 32'd5);
        tick();
        issue(1'b1, 8'hF0);
        chk("wrap_fault", 32'(fault),   32'h1);
        chk("wrap_addr",  32'(address), 32'd5);

        // Selection change while halted
        programSelectIn = 8'h08;
        tick();
`ifdef FETCH_PROG_RESTART_EN
        chk("rs_idle_halt",  32'(halted),        32'h0);
        chk("rs_idle_fault", 32'(fault),         32'h0);
        chk("rs_idle_count", 32'(instrCount),    32'h0);
        chk("rs_idle_addr",  32'(address),       32'h0);
        chk("rs_idle_sel",   32'(programSelect), 32'h01);
        tick();
        chk("rs_fetch_sel",  32'(programSelect), 32'h08);
        chk("rs_fetch_addr", 32'(address),       32'h0);
        tick();
        chk("rs_issue_valid", 32'(instrValid), 32'h1);
`else
        tick();
        tick();
        chk("nors_halt",  32'(halted),        32'h1);
        chk("nors_sel",   32'(programSelect), 32'h01);
        chk("nors_addr",  32'(address),       32'd5);
        chk("nors_count", 32'(instrCount),    32'd2);
`endif

        // Randomized walks
        for (int w = 0; w < 8; w++) begin
            fill_mem(4);
            walk(8'(1 << (w % 8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch controller that sits directly upstream of the instruction memory. It drives the memory's `address` and `programSelect` inputs and latches the returned 16-bit `instruction` into an instruction register. It presents that register to the execute stage through a valid/done handshake, and applies the relative jumps that the execute stage resolves. It also detects HALT (opcode `1110`), flags out-of-range program counters, and counts retired instructions.

## Interface
- `PROG_DEPTH`, default 128: number of valid instruction slots. A PC value `>= PROG_DEPTH` is a fault.
- `COUNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rstN`  in  1  reset. One clock; reset is synchronous and active-low.
- `programSelectIn`  in  8  program selection switches, one-hot or multi-hot.
- `programSelect`  out  8  latched selection, driven to the instruction memory.
- `address`  out  8  current PC, driven to the instruction memory.
- `instruction`  in  16  combinational memory read data for `address`.
- `instrReg`  out  16  latched instruction presented to the execute stage.
- `instrValid`  out  1  `instrReg` holds an instruction awaiting execution.
- `execDone`  in  1  execute stage has finished with `instrReg`.
- `jumpTaken`  in  1  qualifies `execDone`: apply `jumpOffset`.
- `jumpOffset`  in  8  two's-complement offset relative to PC+1.
- `halted`  out  1  sequencer stopped, either on HALT or on a fault.
- `fault`  out  1  a jump target or the sequential PC reached `>= PROG_DEPTH`.
- `instrCount`  out  COUNT_W  retired instructions, saturating.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE (one cycle):
  - `programSelect <= programSelectIn`
  - PC = 0
  - go to FETCH.
- FETCH (one cycle): `address` = PC.
  - `instruction[15:12] == 4'b1110`: go to HALT, set `halted`. IR is not loaded.
  - Otherwise: `instrReg <= instruction`, go to ISSUE.
- ISSUE:
  - `instrValid` = 1 for as long as the state holds.
  - Wait for `execDone`. Once `execDone` is accepted, `instrReg` must not change.
  - On `execDone`, the next PC is:
    - `jumpTaken ? PC + 1 + sext(jumpOffset) : PC + 1`, computed modulo 256 in 8 bits.
  - If next PC `< PROG_DEPTH`: load PC, increment `instrCount` (saturates at all-ones), go to FETCH.
  - If next PC `>= PROG_DEPTH`: PC unchanged, set `fault` and `halted`, go to HALT. `instrCount` still increments, because the instruction itself retired.
- HALT:
  - Terminal state. `address` holds the last PC.
  - `instrValid` = 0.
  - The only exit is reset, or the restart described under Configuration.
- `execDone` and `jumpTaken` are ignored in every state other than ISSUE.
- `jumpOffset` of 0xFF with `jumpTaken` = 1 re-executes the same PC. This is legal.
- Wrap example: PC 5 with offset 0xF0 gives 0xF6 (246), which is a fault at the default depth.

## Timing
- Reset values:
  - State IDLE, PC 0, `address` 0.
  - `programSelect` 0, `instrReg` 0, `instrValid` 0.
  - `halted` 0, `fault` 0, `instrCount` 0.
- Relative to the first cycle with `rstN` = 1:
  - cycle 0: IDLE
  - cycle 1: FETCH
  - cycle 2: `instrValid` = 1
- Best-case throughput: 2 cycles per instruction (`execDone` high in the first ISSUE cycle).
- Outputs are registered, except `address`, which is a direct copy of the PC register.
- `instruction` is sampled only at the FETCH clock edge.
- `rstN` low in any state returns every register to its reset value at the next edge. An in-flight `execDone` in that same cycle is discarded.

## Configuration
- `FETCH_PROG_RESTART_EN` defined:
  - In FETCH, ISSUE or HALT, if `programSelectIn != programSelect`, the next state is IDLE.
  - That transition clears PC, `instrValid`, `halted`, `fault` and `instrCount`.
  - The new selection is latched in the IDLE cycle.
  - The restart has priority over `execDone` in the same cycle.
- `FETCH_PROG_RESTART_EN` undefined:
  - `programSelectIn` is sampled only in IDLE.
  - Later changes are ignored until reset.

## Test plan
- Straight-line program:
  - Memory holds 0x0102, 0x2F10, 0xE000.
  - `execDone` held at 1.
  - Required: `instrReg` shows 0x0102 then 0x2F10 on cycles 2 and 4; `halted` = 1 with `address` = 2; `instrCount` = 2.
- Backward jump:
  - At PC 12, `execDone` = 1, `jumpTaken` = 1, `jumpOffset` = 0xF6 (-10).
  - Required: next FETCH `address` = 3; `instrCount` increments.
- Fault:
  - At PC 120, `jumpTaken` with offset 0x10.
  - Required: `fault` = 1 and `halted` = 1; PC stays 120; `instrValid` = 0.
- Stall:
  - `execDone` held low for 5 cycles in ISSUE.
  - Required: `instrValid` stays 1; `instrReg` and `address` are stable; no PC advance.
- Reset mid-ISSUE:
  - `rstN` = 0 in the same cycle as `execDone` = 1.
  - Required: all outputs at reset values next cycle; `instrCount` = 0.
- Restart (macro defined):
  - Change `programSelectIn` from 0x01 to 0x08 while halted.
  - Required: IDLE, then fetch at address 0 with `programSelect` = 0x08 two cycles later.
  - With the macro undefined: sequencer stays halted.
